// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Magnitude of a width-bit operand carried in a 64-bit container.
  // The most negative value maps to 2^(width-1), which still fits unsigned.
  function automatic logic [WIDTH_MAX-1:0] abs_w(input logic [WIDTH_MAX-1:0] value,
                                                 input int                   width,
                                                 input logic                 signed_mode);
    logic [WIDTH_MAX-1:0] mask;
    logic [5:0]           msb_idx;
    mask    = (width >= WIDTH_MAX) ? '1 : ((64'd1 << width) - 64'd1);
    msb_idx = 6'(width - 1);
    if (signed_mode && value[msb_idx])
      abs_w = (~value + 64'd1) & mask;
    else
      abs_w = value & mask;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: conditional add into the upper half, then a
// right shift of {carry, product}.
module mult_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 carry,
  input  logic [2*WIDTH-1:0]   product,
  input  logic [WIDTH-1:0]     regcand,
  output logic [2*WIDTH:0]     step_nxt
);

  logic [WIDTH:0] hi_sum;

  // Add the multiplicand when the current multiplier bit is set, then shift.
  always_comb begin
    hi_sum = {carry, product[2*WIDTH-1:WIDTH]};
    if (product[0])
      hi_sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, regcand};
    step_nxt = {1'b0, hi_sum, product[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier with internal control FSM, start/done
// handshake, abort and unsigned/signed mode. Signed operands are multiplied
// as magnitudes and the sign is applied in a single fix-up cycle.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic                 abort,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [CNT_W-1:0]     counter
);

  state_t               state;
  logic [WIDTH-1:0]     regcand;
  logic                 carry;
  logic                 neg;

  logic [WIDTH-1:0]     lier_mag;
  logic [WIDTH-1:0]     cand_mag;
  logic [2*WIDTH:0]     step_nxt;

  assign lier_mag = WIDTH'(abs_w(64'(multiplier),   WIDTH, signed_mode));
  assign cand_mag = WIDTH'(abs_w(64'(multiplicand), WIDTH, signed_mode));

  mult_step #(.WIDTH(WIDTH)) u_step (
    .carry    (carry),
    .product  (product),
    .regcand  (regcand),
    .step_nxt (step_nxt)
  );

  // Control FSM with registered handshake outputs and the working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      product <= '0;
      counter <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
      regcand <= '0;
      carry   <= 1'b0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts directly so back-to-back operations lose no cycle;
          // abort has no effect here and start takes priority over it.
          if (start) begin
            regcand <= cand_mag;
            product <= {{WIDTH{1'b0}}, lier_mag};
            carry   <= 1'b0;
            neg     <= signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
            counter <= '0;
            state   <= CALC;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (abort) begin
            product <= '0;
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            carry   <= step_nxt[2*WIDTH];
            product <= step_nxt[2*WIDTH-1:0];
            counter <= counter + CNT_W'(1);
            if (counter == CNT_W'(WIDTH - 1))
              state <= FIX;
          end
        end
        FIX: begin
          if (abort) begin
            product <= '0;
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            if (neg)
              product <= -product;
            state <= DONE;
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: WIDTH=8 and WIDTH=32 instances, table vectors,
// handshake corner sequences and randomized operands against a plain
// arithmetic reference.
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, sm8 = 1'b0, abort8 = 1'b0;
  logic [7:0]  lier8 = '0, cand8 = '0;
  logic        ready8, busy8, done8;
  logic [15:0] product8;
  logic [3:0]  counter8;

  logic        start32 = 1'b0, sm32 = 1'b0, abort32 = 1'b0;
  logic [31:0] lier32 = '0, cand32 = '0;
  logic        ready32, busy32, done32;
  logic [63:0] product32;
  logic [5:0]  counter32;

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .multiplier(lier8), .multiplicand(cand8), .abort(abort8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8), .counter(counter8)
  );

  seq_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm32),
    .multiplier(lier32), .multiplicand(cand32), .abort(abort32),
    .ready(ready32), .busy(busy32), .done(done32), .product(product32), .counter(counter32)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: ordinary integer multiplication of the operands as numbers.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input int w, input logic s);
    longint sa, sb;
    logic [63:0] r;
    if (s) begin
      sa = longint'(a);
      sb = longint'(b);
      if (((a >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
      if (((b >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
      r = 64'(sa * sb);
    end else begin
      r = a * b;
    end
    if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
    lier8 = a; cand8 = b; sm8 = s; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lier8 = 8'($urandom); cand8 = 8'($urandom); sm8 = 1'($urandom);
  endtask

  // Counts edges until done is seen; returns at the negedge inside the done cycle.
  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 100) begin
      @(posedge clk); n++; @(negedge clk);
    end
    if (done8 !== 1'b1) begin
      nvec++; nerr++;
      $display("FAIL timeout8: no done after %0d cycles", n);
    end
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s);
    lier32 = a; cand32 = b; sm32 = s; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    lier32 = $urandom; cand32 = $urandom; sm32 = 1'($urandom);
  endtask

  task automatic wait_done32(output int n);
    n = 0;
    while (done32 !== 1'b1 && n < 200) begin
      @(posedge clk); n++; @(negedge clk);
    end
    if (done32 !== 1'b1) begin
      nvec++; nerr++;
      $display("FAIL timeout32: no done after %0d cycles", n);
    end
  endtask

  task automatic step;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic [7:0]  ra, rb;
    logic [31:0] wa, wb;
    logic        rs;

    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tbl[3] = '{8'h07, 8'hFD, 1'b1, 16'hFFEB};
    tbl[4] = '{8'h00, 8'hC8, 1'b0, 16'h0000};
    tbl[5] = '{8'h0C, 8'h0C, 1'b0, 16'h0090};
    tbl[6] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
    tbl[7] = '{8'h80, 8'h7F, 1'b1, 16'hC080};

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready8",   64'(ready8),    64'd1);
    chk("rst_busy8",    64'(busy8),     64'd0);
    chk("rst_done8",    64'(done8),     64'd0);
    chk("rst_product8", 64'(product8),  64'd0);
    chk("rst_counter8", 64'(counter8),  64'd0);
    chk("rst_ready32",  64'(ready32),   64'd1);
    chk("rst_product32", product32,     64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: product, latency (WIDTH+1 edges after accept), pulse width
    for (int i = 0; i < 8; i++) begin
      issue8(tbl[i].a, tbl[i].b, tbl[i].s);
      chk($sformatf("tbl%0d_busy", i), 64'(busy8), 64'd1);
      wait_done8(n);
      chk($sformatf("tbl%0d_product", i), 64'(product8), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_latency", i), 64'(n), 64'd9);
      chk($sformatf("tbl%0d_ready_at_done", i), 64'(ready8), 64'd1);
      step();
      chk($sformatf("tbl%0d_done_onecycle", i), 64'(done8), 64'd0);
      chk($sformatf("tbl%0d_ready_after", i), 64'(ready8), 64'd1);
      chk($sformatf("tbl%0d_product_hold", i), 64'(product8), 64'(tbl[i].exp));
    end

    // Back-to-back accept from the DONE cycle
    issue8(8'd0, 8'd200, 1'b0);
    wait_done8(n);
    chk("b2b_first_product", 64'(product8), 64'h0);
    issue8(8'd3, 8'd5, 1'b0);
    chk("b2b_busy", 64'(busy8), 64'd1);
    wait_done8(n);
    chk("b2b_second_product", 64'(product8), 64'h000F);
    chk("b2b_second_latency", 64'(n), 64'd9);
    step();

    // start with new operands while busy is ignored
    issue8(8'd9, 8'd11, 1'b0);
    repeat (3) step();
    chk("calc_counter", 64'(counter8), 64'd3);
    lier8 = 8'd200; cand8 = 8'd200; sm8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    wait_done8(n);
    chk("ignore_start_product", 64'(product8), 64'd99);
    chk("ignore_start_latency", 64'(n), 64'd5);
    step();

    // abort mid-CALC
    issue8(8'd100, 8'd100, 1'b0);
    repeat (2) step();
    abort8 = 1'b1;
    step();
    abort8 = 1'b0;
    chk("abort_ready",   64'(ready8),   64'd1);
    chk("abort_busy",    64'(busy8),    64'd0);
    chk("abort_product", 64'(product8), 64'd0);
    chk("abort_done",    64'(done8),    64'd0);
    pulses = 0;
    repeat (15) begin
      step();
      if (done8) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    // abort in DONE and in IDLE has no effect
    issue8(8'd7, 8'd9, 1'b0);
    wait_done8(n);
    abort8 = 1'b1;
    step();
    abort8 = 1'b0;
    chk("abort_in_done_product", 64'(product8), 64'h3F);
    chk("abort_in_done_ready",   64'(ready8),   64'd1);
    abort8 = 1'b1;
    step();
    abort8 = 1'b0;
    chk("abort_in_idle_product", 64'(product8), 64'h3F);

    // abort and start together in IDLE: start wins
    abort8 = 1'b1;
    issue8(8'd13, 8'd11, 1'b0);
    abort8 = 1'b0;
    chk("abort_start_busy", 64'(busy8), 64'd1);
    wait_done8(n);
    chk("abort_start_product", 64'(product8), 64'h8F);
    step();

    // Asynchronous reset mid-CALC
    issue8(8'd50, 8'd60, 1'b0);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready",   64'(ready8),   64'd1);
    chk("arst_busy",    64'(busy8),    64'd0);
    chk("arst_done",    64'(done8),    64'd0);
    chk("arst_product", 64'(product8), 64'd0);
    chk("arst_counter", 64'(counter8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      step();
      if (done8) pulses++;
    end
    chk("arst_no_done", 64'(pulses), 64'd0);
    issue8(8'd12, 8'd12, 1'b0);
    wait_done8(n);
    chk("arst_fresh_product", 64'(product8), 64'h0090);
    step();

    // Randomized 8-bit operations, sometimes back-to-back
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      issue8(ra, rb, rs);
      wait_done8(n);
      chk($sformatf("rand8_%0d_%0h_%0h_s%0d", i, ra, rb, rs), 64'(product8),
          ref_mul(64'(ra), 64'(rb), 8, rs));
      chk($sformatf("rand8_%0d_latency", i), 64'(n), 64'd9);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    // WIDTH=32
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done32(n);
    chk("w32_umax_product", product32, 64'hFFFF_FFFE_0000_0001);
    chk("w32_umax_latency", 64'(n), 64'd33);
    step();
    issue32(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done32(n);
    chk("w32_intmin_product", product32, 64'h4000_0000_0000_0000);
    step();
    for (int i = 0; i < 10; i++) begin
      wa = $urandom;
      wb = $urandom;
      rs = 1'($urandom_range(0, 1));
      issue32(wa, wb, rs);
      wait_done32(n);
      chk($sformatf("rand32_%0d_%0h_%0h_s%0d", i, wa, wb, rs), product32,
          ref_mul(64'(wa), 64'(wb), 32, rs));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
